// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared constants, slot data type and BCD decode function for
//               active-low seven-segment display paths.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;

    // Everything the scanner needs to know about one digit for one slot.
    typedef struct packed {
        logic [3:0] bcd;
        logic       dp;
        logic       blank;
        logic       blink;
    } slot_t;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/bcd_to_seg7.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_seg7
// Description : Combinational BCD nibble to active-low {g..a} segment decoder.
//               Non-BCD codes decode to all segments off.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    assign o_seg = bcd_to_seg(i_bcd);

endmodule : bcd_to_seg7
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : Time-multiplexed common-anode seven-segment scanner with
//               anti-ghost dead time, per-digit blanking and blinking.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int DIGIT_DIV    = 25000,
    parameter int DEAD_CYCLES  = 500,
    parameter int BLINK_FRAMES = 100
)
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [4*N_DIGITS-1:0] i_bcd,
    input  logic [N_DIGITS-1:0]   i_dp,
    input  logic [N_DIGITS-1:0]   i_blank,
    input  logic [N_DIGITS-1:0]   i_blink,
    output logic [6:0]            o_seg_n,
    output logic                  o_dp_n,
    output logic [N_DIGITS-1:0]   o_an_n
);

    localparam int IDX_W = (N_DIGITS > 1)     ? $clog2(N_DIGITS)     : 1;
    localparam int DIV_W = $clog2(DIGIT_DIV);
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(DIGIT_DIV - 1);
    localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [FRM_W-1:0] c_FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    // ------------------------------------------------------------------------
    // Scan state
    // ------------------------------------------------------------------------
    logic [DIV_W-1:0] r_div_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [FRM_W-1:0] r_frame_cnt;
    logic             r_phase;
    slot_t            r_cap;

    logic             w_div_zero;
    logic             w_div_wrap;
    logic             w_idx_wrap;
    logic             w_frm_wrap;

    assign w_div_zero = (r_div_cnt == '0);
    assign w_div_wrap = (r_div_cnt == c_DIV_LAST);
    assign w_idx_wrap = w_div_wrap && (r_idx == c_IDX_LAST);
    assign w_frm_wrap = w_idx_wrap && (r_frame_cnt == c_FRM_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div_cnt   <= '0;
            r_idx       <= '0;
            r_frame_cnt <= '0;
            r_phase     <= 1'b0;
        end else begin
            if (w_div_wrap) begin
                r_div_cnt <= '0;
                r_idx     <= w_idx_wrap ? '0 : r_idx + IDX_W'(1);
                if (w_idx_wrap) begin
                    r_frame_cnt <= w_frm_wrap ? '0 : r_frame_cnt + FRM_W'(1);
                    if (w_frm_wrap) begin
                        r_phase <= ~r_phase;
                    end
                end
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Per-slot input capture
    // ------------------------------------------------------------------------
    slot_t                 w_live;
    slot_t                 w_cur;
    logic [N_DIGITS-1:0]   w_an_sel;

    always_comb begin
        w_live   = '0;
        w_an_sel = '1;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_live.bcd   = i_bcd[4*k +: 4];
                w_live.dp    = i_dp[k];
                w_live.blank = i_blank[k];
                w_live.blink = i_blink[k];
                w_an_sel[k]  = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cap <= '0;
        end else if (w_div_zero) begin
            r_cap <= w_live;
        end
    end

    // The capture register only holds this slot's data from cycle 1 onward,
    // so cycle 0 (which matters when there is no dead window) uses the live
    // value that is being captured in that same cycle.
    assign w_cur = w_div_zero ? w_live : r_cap;

    // ------------------------------------------------------------------------
    // Dead window
    // ------------------------------------------------------------------------
    logic w_dead;

    generate
        if (DEAD_CYCLES == 0) begin : g_no_dead
            assign w_dead = 1'b0;
        end else begin : g_dead
            localparam logic [DIV_W-1:0] c_DEAD = DIV_W'(DEAD_CYCLES);
            assign w_dead = (r_div_cnt < c_DEAD);
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Decode and registered outputs
    // ------------------------------------------------------------------------
    logic [6:0] w_seg;
    logic       w_dark;
    logic       w_off;

    bcd_to_seg7 u_decode (
        .i_bcd (w_cur.bcd),
        .o_seg (w_seg)
    );

    // A dark digit keeps its anode slot so scan duty stays uniform.
    assign w_dark = w_cur.blank | (w_cur.blink & r_phase);
    assign w_off  = w_dead | w_dark;

    logic [6:0]          r_seg_n;
    logic                r_dp_n;
    logic [N_DIGITS-1:0] r_an_n;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_an_n  <= '1;
            r_seg_n <= SEG_BLANK;
            r_dp_n  <= 1'b1;
        end else begin
            r_an_n  <= w_dead ? '1 : w_an_sel;
            r_seg_n <= w_off ? SEG_BLANK : w_seg;
            r_dp_n  <= w_off ? 1'b1 : ~w_cur.dp;
        end
    end

    assign o_an_n  = r_an_n;
    assign o_seg_n = r_seg_n;
    assign o_dp_n  = r_dp_n;

endmodule : seg7_scan_driver
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_driver
// Description : Directed self-checking bench for seg7_scan_driver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] bcd   = 16'h0000;
    logic [3:0]  dp    = 4'b0000;
    logic [3:0]  blank = 4'b0000;
    logic [3:0]  blink = 4'b0000;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;

    int g;
    int checks = 0;
    int errors = 0;

    seg7_scan_driver #(
        .N_DIGITS     (4),
        .DIGIT_DIV    (8),
        .DEAD_CYCLES  (2),
        .BLINK_FRAMES (2)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_bcd   (bcd),
        .i_dp    (dp),
        .i_blank (blank),
        .i_blink (blink),
        .o_seg_n (seg_n),
        .o_dp_n  (dp_n),
        .o_an_n  (an_n)
    );

    always #5 clk = ~clk;

    // g = number of rising edges since reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) g <= 0;
        else        g <= g + 1;
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic goto(input int target);
        if (target < g) begin
            checks++;
            errors++;
            $display("FAIL goto target=%0d already at g=%0d", target, g);
        end else begin
            repeat (target - g) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        bcd = 16'h8888; dp = 4'b1111; blank = 4'b0000; blink = 4'b0000;
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (an_n !== 4'b1111) begin errors++; $display("FAIL reset_an got %b want 1111", an_n); end
        checks++; if (seg_n !== 7'h7F) begin errors++; $display("FAIL reset_seg got %h want 7f", seg_n); end
        checks++; if (dp_n !== 1'b1) begin errors++; $display("FAIL reset_dp got %b want 1", dp_n); end
    endtask

    task automatic test_scan();
        int         gs  [11] = '{0, 1, 2, 3, 8, 9, 10, 11, 19, 27, 35};
        logic [3:0] anx [11] = '{4'hF, 4'hF, 4'hF, 4'hE, 4'hE, 4'hF, 4'hF, 4'hD, 4'hB, 4'h7, 4'hE};
        logic [6:0] sgx [11] = '{7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h19, 7'h7F, 7'h7F, 7'h30, 7'h24, 7'h79, 7'h19};
        bcd = 16'h1234; dp = 4'b0000; blank = 4'b0000; blink = 4'b0000;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            goto(gs[i]);
            checks++; if (an_n !== anx[i]) begin errors++; $display("FAIL scan_an g=%0d got %b want %b", g, an_n, anx[i]); end
            checks++; if (seg_n !== sgx[i]) begin errors++; $display("FAIL scan_seg g=%0d got %h want %h", g, seg_n, sgx[i]); end
            checks++; if (dp_n !== 1'b1) begin errors++; $display("FAIL scan_dp g=%0d got %b want 1", g, dp_n); end
        end
    endtask

    task automatic test_decode();
        int         gs  [4] = '{3, 11, 19, 27};
        logic [3:0] anx [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
        logic [6:0] sgx [4] = '{7'h40, 7'h7F, 7'h10, 7'h7F};
        bcd = 16'hF9A0; dp = 4'b0000; blank = 4'b0000; blink = 4'b0000;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            goto(gs[i]);
            checks++; if (an_n !== anx[i]) begin errors++; $display("FAIL decode_an g=%0d got %b want %b", g, an_n, anx[i]); end
            checks++; if (seg_n !== sgx[i]) begin errors++; $display("FAIL decode_seg g=%0d got %h want %h", g, seg_n, sgx[i]); end
        end
    endtask

    task automatic test_blink();
        int         gs  [6] = '{3, 35, 67, 75, 99, 131};
        logic [3:0] anx [6] = '{4'hE, 4'hE, 4'hE, 4'hD, 4'hE, 4'hE};
        logic [6:0] sgx [6] = '{7'h00, 7'h00, 7'h7F, 7'h40, 7'h7F, 7'h00};
        bcd = 16'h0008; dp = 4'b0000; blank = 4'b0000; blink = 4'b0001;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            goto(gs[i]);
            checks++; if (an_n !== anx[i]) begin errors++; $display("FAIL blink_an g=%0d got %b want %b", g, an_n, anx[i]); end
            checks++; if (seg_n !== sgx[i]) begin errors++; $display("FAIL blink_seg g=%0d got %h want %h", g, seg_n, sgx[i]); end
        end
    endtask

    task automatic test_dp_blank();
        int         gs  [6] = '{11, 17, 19, 24, 25, 27};
        logic [3:0] anx [6] = '{4'hD, 4'hF, 4'hB, 4'hB, 4'hF, 4'h7};
        logic [6:0] sgx [6] = '{7'h30, 7'h7F, 7'h24, 7'h24, 7'h7F, 7'h7F};
        logic       dpx [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        bcd = 16'h1234; dp = 4'b0100; blank = 4'b1000; blink = 4'b0000;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            goto(gs[i]);
            checks++; if (an_n !== anx[i]) begin errors++; $display("FAIL dpblank_an g=%0d got %b want %b", g, an_n, anx[i]); end
            checks++; if (seg_n !== sgx[i]) begin errors++; $display("FAIL dpblank_seg g=%0d got %h want %h", g, seg_n, sgx[i]); end
            checks++; if (dp_n !== dpx[i]) begin errors++; $display("FAIL dpblank_dp g=%0d got %b want %b", g, dp_n, dpx[i]); end
        end
    endtask

    task automatic test_no_tear();
        int         gs  [4] = '{12, 16, 19, 43};
        logic [3:0] anx [4] = '{4'hD, 4'hD, 4'hB, 4'hD};
        logic [6:0] sgx [4] = '{7'h30, 7'h30, 7'h24, 7'h12};
        bcd = 16'h1234; dp = 4'b0000; blank = 4'b0000; blink = 4'b0000;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            goto(gs[i]);
            checks++; if (an_n !== anx[i]) begin errors++; $display("FAIL tear_an g=%0d got %b want %b", g, an_n, anx[i]); end
            checks++; if (seg_n !== sgx[i]) begin errors++; $display("FAIL tear_seg g=%0d got %h want %h", g, seg_n, sgx[i]); end
            if (i == 0) bcd = 16'h1254;
        end
    endtask

    task automatic test_reset_midslot();
        int         gs  [3] = '{0, 2, 3};
        logic [3:0] anx [3] = '{4'hF, 4'hF, 4'hE};
        logic [6:0] sgx [3] = '{7'h7F, 7'h7F, 7'h19};
        bcd = 16'h1234; dp = 4'b0100; blank = 4'b0000; blink = 4'b0000;
        do_reset();
        goto(20);
        checks++; if (an_n !== 4'hB) begin errors++; $display("FAIL midrst_pre_an got %b want 1011", an_n); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (an_n !== 4'hF) begin errors++; $display("FAIL midrst_async_an got %b want 1111", an_n); end
        checks++; if (seg_n !== 7'h7F) begin errors++; $display("FAIL midrst_async_seg got %h want 7f", seg_n); end
        checks++; if (dp_n !== 1'b1) begin errors++; $display("FAIL midrst_async_dp got %b want 1", dp_n); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            goto(gs[i]);
            checks++; if (an_n !== anx[i]) begin errors++; $display("FAIL midrst_an g=%0d got %b want %b", g, an_n, anx[i]); end
            checks++; if (seg_n !== sgx[i]) begin errors++; $display("FAIL midrst_seg g=%0d got %h want %h", g, seg_n, sgx[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_decode();
        test_blink();
        test_dp_blank();
        test_no_tear();
        test_reset_midslot();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_seg7_scan_driver
`default_nettype wire
